// File: rtl/note2dds_sched_if.sv
// Voice-write, shared-converter and DDS-bank signals of the note-to-DDS scheduler.
// master = voice allocator / converter side, slave = scheduler.
interface note2dds_sched_if #(
    parameter int unsigned VOICES = 8
);
    logic                   voice_we;
    logic [3:0]             voice_idx;
    logic [6:0]             voice_note;
    logic                   voice_gate;
    logic [6:0]             conv_note;
    logic [31:0]            conv_adder;
    logic [32*VOICES-1:0]   adder_bus;
    logic                   upd_strobe;
    logic [3:0]             upd_voice;
    logic                   busy;

    modport master (
        output voice_we, voice_idx, voice_note, voice_gate, conv_adder,
        input  conv_note, adder_bus, upd_strobe, upd_voice, busy
    );

    modport slave (
        input  voice_we, voice_idx, voice_note, voice_gate, conv_adder,
        output conv_note, adder_bus, upd_strobe, upd_voice, busy
    );
endinterface

// File: rtl/note2dds_sched.sv
// Time-multiplexes one note-to-phase-increment converter across VOICES voices,
// round-robin over voices whose note/gate was written since their last conversion.
module note2dds_sched #(
    parameter int unsigned VOICES   = 8,
    parameter int unsigned CONV_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    note2dds_sched_if.slave   bus
);
    localparam int unsigned IW = 4;
    localparam int unsigned XW = IW + 1;
    localparam int unsigned NW = 7;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    state_t             state, state_nxt;
    logic [NW-1:0]      note  [VOICES];
    logic [AW-1:0]      adder [VOICES];
    logic [VOICES-1:0]  gate, dirty, dirty_nxt;
    logic [IW-1:0]      rr_ptr, cur_idx, upd_voice;
    logic [NW-1:0]      cur_note;
    logic [CW-1:0]      wait_cnt;
    logic               upd_strobe;

    logic               wr_ok;
    logic               hi_found, lo_found, sel_found;
    logic [IW-1:0]      hi_idx, lo_idx, sel_idx;
    logic [NW-1:0]      sel_note;

    assign wr_ok = bus.voice_we && ({1'b0, bus.voice_idx} < XW'(VOICES));

    // Round-robin pick: lowest dirty voice above rr_ptr, else lowest dirty voice (wrap).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        sel_note = '0;
        for (int unsigned v = 0; v < VOICES; v++) begin
            if (dirty[v] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = IW'(v);
            end
            if (dirty[v] && !hi_found && (IW'(v) > rr_ptr)) begin
                hi_found = 1'b1;
                hi_idx   = IW'(v);
            end
        end
        sel_found = hi_found || lo_found;
        sel_idx   = hi_found ? hi_idx : lo_idx;
        for (int unsigned v = 0; v < VOICES; v++) begin
            if (sel_idx == IW'(v)) sel_note = note[v];
        end
    end

    // A write in the same cycle as selection/clear of that voice keeps it dirty.
    always_comb begin
        dirty_nxt = dirty;
        for (int unsigned v = 0; v < VOICES; v++) begin
            if ((state == IDLE) && sel_found && (sel_idx == IW'(v))) dirty_nxt[v] = 1'b0;
            if (wr_ok && (bus.voice_idx == IW'(v)))                  dirty_nxt[v] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sel_found) state_nxt = ISSUE;
            ISSUE:   state_nxt = (CONV_LAT == 1) ? CAPTURE : WAIT;
            WAIT:    if (wait_cnt == CW'(1)) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned v = 0; v < VOICES; v++) begin
                note[v]  <= '0;
                adder[v] <= '0;
            end
            gate       <= '0;
            dirty      <= '0;
            rr_ptr     <= IW'(VOICES - 1);
            cur_idx    <= '0;
            cur_note   <= '0;
            wait_cnt   <= '0;
            upd_strobe <= 1'b0;
            upd_voice  <= '0;
        end else begin
            dirty      <= dirty_nxt;
            upd_strobe <= (state == CAPTURE);
            for (int unsigned v = 0; v < VOICES; v++) begin
                if (wr_ok && (bus.voice_idx == IW'(v))) begin
                    note[v] <= bus.voice_note;
                    gate[v] <= bus.voice_gate;
                end
                if ((state == CAPTURE) && (cur_idx == IW'(v))) adder[v] <= bus.conv_adder;
            end
            if (state == CAPTURE) upd_voice <= cur_idx;
            if ((state == IDLE) && sel_found) begin
                cur_idx  <= sel_idx;
                cur_note <= sel_note;
                rr_ptr   <= sel_idx;
            end
            if (state == ISSUE)     wait_cnt <= CW'(CONV_LAT - 1);
            else if (state == WAIT) wait_cnt <= wait_cnt - CW'(1);
        end
    end

    // Gate masks the increment so gate-off silences at once while adder[v] is kept.
    for (genvar g = 0; g < VOICES; g++) begin : g_mask
        assign bus.adder_bus[AW*g +: AW] = gate[g] ? adder[g] : '0;
    end

    assign bus.conv_note  = cur_note;
    assign bus.upd_strobe = upd_strobe;
    assign bus.upd_voice  = upd_voice;
    assign bus.busy       = (state != IDLE) || (|dirty);
endmodule

// File: tb/tb_note2dds_sched.sv
// Bench for note2dds_sched: two instances (converter latency 1 and 3) each fed by a
// behavioural note->phase-increment converter (100 MHz clock, 32-bit accumulator).
module tb_note2dds_sched;
    localparam int unsigned NV = 8;
    localparam int unsigned BW = 32 * NV;

    logic       clk = 1'b0;
    logic       reset;
    logic       we;
    logic [3:0] idx;
    logic [6:0] nt;
    logic       gt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    note2dds_sched_if #(.VOICES(NV)) if1 ();
    note2dds_sched_if #(.VOICES(NV)) if3 ();

    assign if1.voice_we   = we;
    assign if1.voice_idx  = idx;
    assign if1.voice_note = nt;
    assign if1.voice_gate = gt;
    assign if3.voice_we   = we;
    assign if3.voice_idx  = idx;
    assign if3.voice_note = nt;
    assign if3.voice_gate = gt;

    // floor(440 * 2^((n-69)/12) * 2^32 / 100e6)
    function automatic logic [31:0] note2adder(input logic [6:0] n);
        real f;
        f = 440.0 * $pow(2.0, (real'(n) - 69.0) / 12.0);
        return 32'($rtoi(f * 42.94967296));
    endfunction

    logic [31:0] c1_q, c3_q0, c3_q1, c3_q2;
    always @(posedge clk) begin
        c1_q  <= note2adder(if1.conv_note);
        c3_q0 <= note2adder(if3.conv_note);
        c3_q1 <= c3_q0;
        c3_q2 <= c3_q1;
    end
    assign if1.conv_adder = c1_q;
    assign if3.conv_adder = c3_q2;

    note2dds_sched #(.VOICES(NV), .CONV_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    note2dds_sched #(.VOICES(NV), .CONV_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

    typedef struct {
        logic [3:0]  idx;
        logic [6:0]  note;
        logic        gate;
        bit          exp_upd;
        logic [31:0] exp_slice;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    task automatic chk_bus(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] slice(input logic [BW-1:0] b, input int v);
        return b[32*v +: 32];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        we    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Write sampled at the next posedge (E0); returns #1 after E0.
    task automatic write(input logic [3:0] i, input logic [6:0] n, input logic g);
        @(negedge clk);
        we  = 1'b1;
        idx = i;
        nt  = n;
        gt  = g;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic wait_strobe(input bit use3, input int budget, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < budget) begin
            @(posedge clk);
            cyc++;
            #1;
            got = use3 ? if3.upd_strobe : if1.upd_strobe;
        end
    endtask

    initial begin
        logic [BW-1:0] eb;
        bit got;
        int cyc;
        int strobes, last_c, doubles;

        tbl[0] = '{4'd2,  7'd69,  1'b1, 1'b1, 32'd18897};
        tbl[1] = '{4'd5,  7'd0,   1'b1, 1'b1, 32'd351};
        tbl[2] = '{4'd12, 7'd60,  1'b1, 1'b0, 32'd0};
        tbl[3] = '{4'd7,  7'd127, 1'b0, 1'b1, 32'd0};
        tbl[4] = '{4'd7,  7'd127, 1'b1, 1'b1, 32'd538754};
        tbl[5] = '{4'd0,  7'd72,  1'b1, 1'b1, 32'd22473};

        reset = 1'b1;
        we = 1'b0; idx = '0; nt = '0; gt = 1'b0;
        do_reset();
        #1;
        chk_bus("rst_bus",    if1.adder_bus, '0);
        chk("rst_conv_note",  32'(if1.conv_note), 0);
        chk("rst_strobe",     32'(if1.upd_strobe), 0);
        chk("rst_upd_voice",  32'(if1.upd_voice), 0);
        chk("rst_busy",       32'(if1.busy), 0);

        // Single write: voice 2, note 69.
        write(4'd2, 7'd69, 1'b1);
        chk("single_busy_early", 32'(if1.busy), 1);
        wait_strobe(1'b0, 10, got, cyc);
        chk("single_got", 32'(got), 1);
        chk("single_lat", 32'(cyc), 3);
        chk("single_voice", 32'(if1.upd_voice), 2);
        eb = '0;
        eb[64 +: 32] = 32'd18897;
        chk_bus("single_bus", if1.adder_bus, eb);
        chk("single_busy_end", 32'(if1.busy), 0);

        // Table-driven single writes on an idle scheduler.
        for (int t = 0; t < 6; t++) begin
            write(tbl[t].idx, tbl[t].note, tbl[t].gate);
            wait_strobe(1'b0, 10, got, cyc);
            chk($sformatf("tbl%0d_got", t), 32'(got), 32'(tbl[t].exp_upd));
            if (tbl[t].exp_upd) begin
                chk($sformatf("tbl%0d_lat", t), 32'(cyc), 3);
                chk($sformatf("tbl%0d_voice", t), 32'(if1.upd_voice), 32'(tbl[t].idx));
                chk($sformatf("tbl%0d_slice", t), slice(if1.adder_bus, int'(tbl[t].idx)), tbl[t].exp_slice);
            end
            chk($sformatf("tbl%0d_busy", t), 32'(if1.busy), 0);
        end

        // All eight voices written back to back with note 60.
        do_reset();
        strobes = 0; last_c = -10; doubles = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c < 8) begin
                we = 1'b1; idx = 4'(c); nt = 7'd60; gt = 1'b1;
            end else begin
                we = 1'b0;
            end
            @(posedge clk);
            #1;
            if (if1.upd_strobe) begin
                if (c == last_c + 1) doubles++;
                chk($sformatf("rr_voice%0d", strobes), 32'(if1.upd_voice), 32'(strobes));
                if (strobes == 0) chk("rr_first", 32'(c), 3);
                else              chk($sformatf("rr_gap%0d", strobes), 32'(c - last_c), 3);
                last_c = c;
                strobes++;
            end
        end
        we = 1'b0;
        chk("rr_count", 32'(strobes), 8);
        chk("rr_doubles", 32'(doubles), 0);
        for (int v = 0; v < 8; v++) chk($sformatf("rr_slice%0d", v), slice(if1.adder_bus, v), 32'd11236);
        chk("rr_busy", 32'(if1.busy), 0);

        // Gate masking on voice 5.
        do_reset();
        write(4'd5, 7'd0, 1'b1);
        wait_strobe(1'b0, 10, got, cyc);
        chk("gate_on", slice(if1.adder_bus, 5), 32'd351);
        write(4'd5, 7'd0, 1'b0);
        chk("gate_off_now", slice(if1.adder_bus, 5), 32'd0);
        wait_strobe(1'b0, 10, got, cyc);
        chk("gate_off_reconv", 32'(got), 1);
        chk("gate_off_slice", slice(if1.adder_bus, 5), 32'd0);
        write(4'd5, 7'd0, 1'b1);
        eb = '0;
        eb[160 +: 32] = 32'd351;
        chk_bus("gate_restore_now", if1.adder_bus, eb);
        wait_strobe(1'b0, 10, got, cyc);
        chk("gate_restore_voice", 32'(if1.upd_voice), 5);
        chk_bus("gate_restore_bus", if1.adder_bus, eb);

        // Rewrite of voice 3 while its conversion is in ISSUE.
        do_reset();
        write(4'd3, 7'd60, 1'b1);
        @(posedge clk);
        #1;
        chk("inflight_conv_note", 32'(if1.conv_note), 60);
        write(4'd3, 7'd69, 1'b1);
        wait_strobe(1'b0, 10, got, cyc);
        chk("inflight_first_got", 32'(got), 1);
        chk("inflight_first", slice(if1.adder_bus, 3), 32'd11236);
        wait_strobe(1'b0, 10, got, cyc);
        chk("inflight_second_got", 32'(got), 1);
        chk("inflight_second_voice", 32'(if1.upd_voice), 3);
        chk("inflight_second", slice(if1.adder_bus, 3), 32'd18897);

        // Reset during WAIT on the CONV_LAT=3 instance.
        do_reset();
        write(4'd1, 7'd69, 1'b1);
        wait_strobe(1'b1, 12, got, cyc);
        chk("lat3_got", 32'(got), 1);
        chk("lat3_lat", 32'(cyc), 5);
        chk("lat3_voice", 32'(if3.upd_voice), 1);
        chk("lat3_slice", slice(if3.adder_bus, 1), 32'd18897);
        write(4'd4, 7'd60, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("lat3_busy_wait", 32'(if3.busy), 1);
        chk("lat3_conv_note", 32'(if3.conv_note), 60);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_bus("rstwait_bus", if3.adder_bus, '0);
        chk("rstwait_conv_note", 32'(if3.conv_note), 0);
        chk("rstwait_strobe", 32'(if3.upd_strobe), 0);
        chk("rstwait_upd_voice", 32'(if3.upd_voice), 0);
        chk("rstwait_busy", 32'(if3.busy), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_strobe(1'b1, 10, got, cyc);
        chk("rstwait_no_strobe", 32'(got), 0);
        chk("rstwait_busy_after", 32'(if3.busy), 0);

        // Out-of-range voice index on a fresh scheduler.
        write(4'd12, 7'd60, 1'b1);
        chk("inv_busy_now", 32'(if1.busy), 0);
        wait_strobe(1'b0, 8, got, cyc);
        chk("inv_no_strobe", 32'(got), 0);
        chk("inv_busy", 32'(if1.busy), 0);
        chk_bus("inv_bus", if1.adder_bus, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/note2dds_sched.md
# note2dds_sched

Time-multiplexed voice scheduler that shares one note-to-DDS phase-increment converter (7-bit MIDI note in, 32-bit ADDER out, registered input stage) among VOICES synth voices. The MIDI/voice-allocation logic writes note and gate per voice. The scheduler queues changed voices, runs them one at a time through the converter, and holds a per-voice 32-bit phase increment register that feeds the voice DDS accumulators. It sits between the voice allocator and the DDS bank.

## Interface
- VOICES, 8: number of voices, 2..16.
- CONV_LAT, 1: converter latency in clocks from NOTE sampled to ADDER valid, 1..4.

- CLK  in  1  system clock, all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- VOICE_WE  in  1  write strobe for a voice's note/gate.
- VOICE_IDX  in  4  voice index; writes with VOICE_IDX ≥ VOICES are ignored.
- VOICE_NOTE  in  7  MIDI note 0..127.
- VOICE_GATE  in  1  voice gate (1 = sounding).
- CONV_NOTE  out  7  note driven to the shared converter's NOTE input.
- CONV_ADDER  in  32  converter's ADDER output.
- ADDER_BUS  out  32*VOICES  per-voice increments; voice v occupies bits [32v+31:32v].
- UPD_STROBE  out  1  one-cycle pulse when a voice increment register is updated.
- UPD_VOICE  out  4  index of the voice updated; valid with UPD_STROBE.
- BUSY  out  1  high when the FSM is not in IDLE or any dirty flag is set.

## Operation
- Per-voice state: note[v] (7b), gate[v] (1b), adder[v] (32b), dirty[v] (1b).
- Write handling, on VOICE_WE with a valid index:
  - note[idx] and gate[idx] load.
  - dirty[idx] is set. Every write sets it, including gate-only changes.
- ADDER_BUS slice v = gate[v] ? adder[v] : 0. This is a combinational mask, so a gate-off silences the voice immediately and adder[v] is retained.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
  - IDLE: if any dirty bit is set, select a voice round-robin, searching upward from rr_ptr+1 with wrap at VOICES. Latch cur_idx and cur_note = note[sel], clear dirty[sel], set rr_ptr = sel, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: CONV_NOTE = cur_note (the converter samples it at the end of this cycle). Go to CAPTURE if CONV_LAT = 1, else load wait_cnt = CONV_LAT-1 and go to WAIT.
  - WAIT: hold CONV_NOTE, decrement wait_cnt, go to CAPTURE when it reaches 1.
  - CAPTURE: adder[cur_idx] <= CONV_ADDER, assert UPD_STROBE/UPD_VOICE for the following cycle, go to IDLE.
- CONV_NOTE holds cur_note from ISSUE until the next selection, so converter input is stable during WAIT and CAPTURE.
- Simultaneous events and boundaries:
  - A write to the voice being selected in the same IDLE cycle: the set wins, so dirty stays 1 and the voice is reconverted later with the new note.
  - A write to cur_idx during ISSUE/WAIT/CAPTURE: the in-flight conversion completes with the old cur_note and the voice is re-queued via dirty.
  - All voices dirty: served in index order from rr_ptr+1. No voice waits more than VOICES service slots.
  - Notes 0..127 are passed through unchanged; range handling is the converter's job.
- RESET, including mid-conversion:
  - state = IDLE; rr_ptr = VOICES-1, so voice 0 is served first.
  - All note, gate, adder and dirty cleared; CONV_NOTE = 0; UPD_STROBE = 0; UPD_VOICE = 0.
  - An in-flight result is discarded.

## Timing
- Service slot = 2 + CONV_LAT cycles per voice (IDLE, ISSUE, CONV_LAT-1 × WAIT, CAPTURE).
- Idle scheduler, write sampled at edge E0:
  - dirty is set at E0.
  - Selection happens at E1.
  - The converter samples the note at E2.
  - adder[v] updates at edge E(2+CONV_LAT).
  - UPD_STROBE is high in the cycle after that edge, coincident with the new ADDER_BUS value.
- Gate changes affect ADDER_BUS in the cycle after the write edge.
- Back-to-back dirty voices: UPD_STROBE pulses every 2+CONV_LAT cycles. It never stays high for two consecutive cycles.
- BUSY deasserts in the cycle after the last CAPTURE when no dirty bit remains.

## Test plan
- Reset, then a single write (voice 2, note 69, gate 1), bench using a real converter model with CONV_LAT = 1:
  - UPD_STROBE fires 3 cycles after the write edge with UPD_VOICE = 2.
  - Slice 2 = 18897.
  - All other slices are 0.
- Write voices 0..7 with note 60 in consecutive cycles:
  - Eight strobes, 3 cycles apart, voices in order 0..7.
  - Every slice = 11236; BUSY drops after the last strobe.
- Voice 5 note 0 gate 1 (slice = 351), then gate 0 with the same note:
  - Slice 5 reads 0 the cycle after the write.
  - adder[5] is reconverted to 351; setting gate 1 restores 351 with no other change.
- Write voice 3 note 60, then write voice 3 note 69 during its ISSUE cycle:
  - First strobe gives 11236, then a second strobe gives 18897.
- RESET asserted during WAIT with CONV_LAT = 3:
  - All outputs are 0 the next cycle.
  - No strobe occurs; BUSY = 0.
- Invalid index: write with VOICE_IDX = 12 and VOICES = 8:
  - No dirty set, no strobe, BUSY stays 0.
